// File: rtl/conv_seq_pkg.sv
// Shared constants for the convolution tile sequencer:
// instruction field positions, FSM states and the idle instruction word.
package conv_seq_pkg;

  localparam int AW = 11;

  localparam int B_ACC    = 33;
  localparam int B_CEN_P  = 32;
  localparam int B_WEN_P  = 31;
  localparam int B_AP_LSB = 20;
  localparam int B_CEN_X  = 19;
  localparam int B_WEN_X  = 18;
  localparam int B_AX_LSB = 7;
  localparam int B_OF_RD  = 6;
  localparam int B_IF_WR  = 5;
  localparam int B_IF_RD  = 4;
  localparam int B_L0_RD  = 3;
  localparam int B_L0_WR  = 2;
  localparam int B_EXEC   = 1;
  localparam int B_LOAD   = 0;

  localparam logic [33:0] INST_RST = 34'h1_800C_0000;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLR,
    S_W_L0,
    S_W_LOAD,
    S_DRAIN,
    S_X_L0,
    S_EXEC,
    S_FLUSH,
    S_OF_WAIT,
    S_OF_RD,
    S_ACC,
    S_DONE
  } state_e;

endpackage

// File: rtl/conv_tile_sequencer_acc_addr_gen.sv
// PMEM address generator: psum spill address (k, n) or
// accumulation read address for output pixel o at kernel offset k.
module acc_addr_gen
  import conv_seq_pkg::*;
#(
  parameter int IN_W  = 6,
  parameter int OUT_W = 4,
  parameter int KER_W = 3
) (
  input  logic          acc_mode,
  input  logic [3:0]    k,
  input  logic [3:0]    o,
  input  logic [7:0]    n,
  output logic [AW-1:0] addr
);

  localparam int LEN_NIJ = IN_W * IN_W;

  logic [AW-1:0] base;
  logic [AW-1:0] o_row;
  logic [AW-1:0] o_col;
  logic [AW-1:0] k_row;
  logic [AW-1:0] k_col;
  logic [AW-1:0] off;

  always_comb begin
    base  = AW'(k) * AW'(LEN_NIJ);
    o_row = AW'(o) / AW'(OUT_W);
    o_col = AW'(o) % AW'(OUT_W);
    k_row = AW'(k) / AW'(KER_W);
    k_col = AW'(k) % AW'(KER_W);
    // input pixel seen by output o through kernel tap k
    if (acc_mode) begin
      off = (o_row + k_row) * AW'(IN_W) + o_col + k_col;
    end else begin
      off = AW'(n);
    end
    addr = base + off;
  end

endmodule

// File: rtl/conv_tile_sequencer.sv
// Drives the core instruction word through one convolution tile:
// per-kij weight load, execution, psum spill, then SFP accumulation.
module conv_tile_sequencer
  import conv_seq_pkg::*;
#(
  parameter int          row    = 8,
  parameter int          col    = 8,
  parameter int          in_w   = 6,
  parameter int          out_w  = 4,
  parameter int          ker_w  = 3,
  parameter int          drain  = 10,
  parameter logic [10:0] w_base = 11'h400
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        ofifo_valid,
  output logic [33:0] inst,
  output logic        core_reset,
  output logic        busy,
  output logic        out_valid,
  output logic [3:0]  out_idx,
  output logic        done
);

  localparam int LEN_NIJ  = in_w * in_w;
  localparam int LEN_ONIJ = out_w * out_w;
  localparam int LEN_KIJ  = ker_w * ker_w;

  localparam logic [7:0] C_COL   = 8'(col - 1);
  localparam logic [7:0] C_DRAIN = 8'(drain - 1);
  localparam logic [7:0] C_NIJ   = 8'(LEN_NIJ - 1);
  localparam logic [7:0] C_POPS  = 8'(LEN_NIJ);
  localparam logic [7:0] C_FLUSH = 8'(row + col - 1);
  localparam logic [7:0] C_RDS   = 8'(LEN_KIJ);
  localparam logic [7:0] C_PH    = 8'(LEN_KIJ + 2);
  localparam logic [3:0] C_KIJ   = 4'(LEN_KIJ - 1);
  localparam logic [3:0] C_ONIJ  = 4'(LEN_ONIJ - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  wcnt_q, wcnt_d;
  logic [3:0]  k_q, k_d;
  logic [3:0]  o_q, o_d;
  logic        pop_d;

  logic [33:0] inst_q, inst_d;
  logic        core_reset_q, core_reset_d;
  logic        busy_q, busy_d;
  logic        out_valid_q, out_valid_d;
  logic [3:0]  out_idx_q, out_idx_d;
  logic        done_q, done_d;

  logic          pmem_wr;
  logic          acc_rd;
  logic [3:0]    rd_k;
  logic [3:0]    ag_k;
  logic [AW-1:0] ag_addr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      wcnt_q       <= '0;
      k_q          <= '0;
      o_q          <= '0;
      inst_q       <= INST_RST;
      core_reset_q <= 1'b0;
      busy_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      out_idx_q    <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wcnt_q       <= wcnt_d;
      k_q          <= k_d;
      o_q          <= o_d;
      inst_q       <= inst_d;
      core_reset_q <= core_reset_d;
      busy_q       <= busy_d;
      out_valid_q  <= out_valid_d;
      out_idx_q    <= out_idx_d;
      done_q       <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    o_d     = o_q;
    pop_d   = 1'b0;
    wcnt_d  = wcnt_q + {7'd0, inst_q[B_OF_RD]};
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLR;
          cnt_d   = '0;
          k_d     = '0;
        end
      end
      S_CLR: begin
        state_d = S_W_L0;
        cnt_d   = '0;
        wcnt_d  = '0;
      end
      S_W_L0: begin
        if (cnt_q == C_COL) begin
          state_d = S_W_LOAD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_W_LOAD: begin
        if (cnt_q == C_COL) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DRAIN: begin
        if (cnt_q == C_DRAIN) begin
          state_d = S_X_L0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_X_L0: begin
        if (cnt_q == C_NIJ) begin
          state_d = S_EXEC;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_EXEC: begin
        if (cnt_q == C_NIJ) begin
          state_d = S_FLUSH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_FLUSH: begin
        if (cnt_q == C_FLUSH) begin
          state_d = S_OF_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_OF_WAIT: begin
        if (ofifo_valid) begin
          state_d = S_OF_RD;
          pop_d   = 1'b1;
          cnt_d   = 8'd1;
        end
      end
      S_OF_RD: begin
        // cnt counts pops already placed on the instruction word
        if (cnt_q == C_POPS) begin
          cnt_d = '0;
          if (k_q == C_KIJ) begin
            state_d = S_ACC;
            o_d     = '0;
          end else begin
            state_d = S_CLR;
            k_d     = k_q + 4'd1;
          end
        end else if (ofifo_valid) begin
          pop_d = 1'b1;
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_ACC: begin
        if (cnt_q == C_PH) begin
          cnt_d = '0;
          if (o_q == C_ONIJ) begin
            state_d = S_DONE;
          end else begin
            o_d = o_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // a write trails its pop by one cycle and never meets an ACC read
  assign pmem_wr = inst_q[B_OF_RD];
  assign acc_rd  = (state_d == S_ACC) && (cnt_d != 8'd0)
                && (cnt_d <= C_RDS);
  assign rd_k    = cnt_d[3:0] - 4'd1;
  assign ag_k    = pmem_wr ? k_q : rd_k;

  acc_addr_gen #(
    .IN_W  (in_w),
    .OUT_W (out_w),
    .KER_W (ker_w)
  ) u_addr (
    .acc_mode (~pmem_wr),
    .k        (ag_k),
    .o        (o_d),
    .n        (wcnt_q),
    .addr     (ag_addr)
  );

  always_comb begin
    inst_d          = INST_RST;
    inst_d[B_IF_WR] = 1'b0;
    inst_d[B_IF_RD] = 1'b0;
    inst_d[B_L0_WR] = ~inst_q[B_CEN_X];
    inst_d[B_ACC]   = ~inst_q[B_CEN_P] & inst_q[B_WEN_P];
    inst_d[B_OF_RD] = pop_d;
    if (state_d == S_W_L0) begin
      inst_d[B_CEN_X] = 1'b0;
      inst_d[B_AX_LSB +: AW] = w_base
        + AW'(k_d) * AW'(col) + AW'(cnt_d);
    end else if (state_d == S_X_L0) begin
      inst_d[B_CEN_X] = 1'b0;
      inst_d[B_AX_LSB +: AW] = AW'(cnt_d);
    end else if (state_d == S_W_LOAD) begin
      inst_d[B_L0_RD] = 1'b1;
      inst_d[B_LOAD]  = 1'b1;
    end else if (state_d == S_EXEC) begin
      inst_d[B_L0_RD] = 1'b1;
      inst_d[B_EXEC]  = 1'b1;
    end
    if (pmem_wr) begin
      inst_d[B_CEN_P] = 1'b0;
      inst_d[B_WEN_P] = 1'b0;
      inst_d[B_AP_LSB +: AW] = ag_addr;
    end else if (acc_rd) begin
      inst_d[B_CEN_P] = 1'b0;
      inst_d[B_AP_LSB +: AW] = ag_addr;
    end
    core_reset_d = (state_d == S_CLR)
                || ((state_d == S_ACC) && (cnt_d == 8'd0));
    busy_d       = (state_d != S_IDLE) && (state_d != S_DONE);
    out_valid_d  = (state_d == S_ACC) && (cnt_d == C_PH);
    out_idx_d    = out_valid_d ? o_d : out_idx_q;
    done_d       = (state_d == S_DONE);
  end

  assign inst       = inst_q;
  assign core_reset = core_reset_q;
  assign busy       = busy_q;
  assign out_valid  = out_valid_q;
  assign out_idx    = out_idx_q;
  assign done       = done_q;

endmodule

// File: tb/tb_conv_tile_sequencer.sv
// Bench for conv_tile_sequencer: randomized ofifo stalls and stray
// starts, checked against sequences derived from the tile's rules.
module tb_conv_tile_sequencer;

  localparam int ROW   = 8;
  localparam int COL   = 8;
  localparam int IN_W  = 6;
  localparam int OUT_W = 4;
  localparam int KER_W = 3;
  localparam int DRAIN = 10;
  localparam int NIJ   = IN_W * IN_W;
  localparam int ONIJ  = OUT_W * OUT_W;
  localparam int KIJ   = KER_W * KER_W;
  localparam int HOLD  = 36;
  localparam logic [33:0] IDLE_INST = 34'h1_800C_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        ofifo_valid = 1'b0;
  logic [33:0] inst;
  logic        core_reset;
  logic        busy;
  logic        out_valid;
  logic [3:0]  out_idx;
  logic        done;

  conv_tile_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .ofifo_valid (ofifo_valid),
    .inst        (inst),
    .core_reset  (core_reset),
    .busy        (busy),
    .out_valid   (out_valid),
    .out_idx     (out_idx),
    .done        (done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ofifo_valid: low for HOLD cycles after every EXEC, then random
  logic p_ex = 1'b0;
  int   hold = 0;
  logic force_hi = 1'b0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (p_ex && !inst[1]) hold = HOLD;
      p_ex = inst[1];
      if (hold > 0) begin
        ofifo_valid = 1'b0;
        hold--;
        force_hi = 1'b1;
      end else if (force_hi) begin
        ofifo_valid = 1'b1;
        force_hi = 1'b0;
      end else begin
        ofifo_valid = ($urandom_range(0, 3) != 0);
      end
    end
  end

  logic        mon_en = 1'b0;
  int          cyc = 0;
  logic [10:0] xq[$];
  logic [10:0] pwq[$];
  logic [10:0] prq[$];
  int          ovq[$];
  int          loadq[$];
  int          execq[$];
  int          gapq[$];
  int          latq[$];
  int bad_l0, bad_pw, bad_acc, bad_pop, bad_misc, bad_ov;
  int cres_n, done_n, l0_n, run_ld, run_ex, done_gap;
  int last_load, last_ex, last_pr, last_ov;
  logic armed;
  logic cenx, cenp, pw, pr;
  logic p_cenx = 1'b0;
  logic p_rd = 1'b0;
  logic p_pread = 1'b0;
  logic p_valid = 1'b0;
  logic p_load = 1'b0;
  logic p_exec = 1'b0;

  always @(negedge clk) begin
    cyc++;
    cenx = ~inst[19];
    cenp = ~inst[32];
    pw   = cenp & ~inst[31];
    pr   = cenp & inst[31];
    if (!mon_en) begin
      xq.delete(); pwq.delete(); prq.delete(); ovq.delete();
      loadq.delete(); execq.delete(); gapq.delete(); latq.delete();
      bad_l0 = 0; bad_pw = 0; bad_acc = 0; bad_pop = 0;
      bad_misc = 0; bad_ov = 0; cres_n = 0; done_n = 0; l0_n = 0;
      run_ld = 0; run_ex = 0; done_gap = 0; armed = 1'b0;
      last_load = 0; last_ex = 0; last_pr = 0; last_ov = 0;
    end else begin
      if (cenx) xq.push_back(inst[17:7]);
      if (cenx && inst[17:7] == 11'd0) gapq.push_back(cyc - last_load);
      if (inst[2] != p_cenx) bad_l0++;
      if (inst[2]) l0_n++;
      if (pw) pwq.push_back(inst[30:20]);
      if (pw != p_rd) bad_pw++;
      if (pr) begin
        prq.push_back(inst[30:20]);
        last_pr = cyc;
      end
      if (inst[33] != p_pread) bad_acc++;
      if (inst[6] && !p_valid) bad_pop++;
      if (inst[5] || inst[4] || !inst[18]) bad_misc++;
      if (!cenx && inst[17:7] != 11'd0) bad_misc++;
      if (!cenp && inst[30:20] != 11'd0) bad_misc++;
      if ((inst[0] || inst[1]) && !inst[3]) bad_misc++;
      if (inst[0]) run_ld++;
      else if (p_load) begin
        loadq.push_back(run_ld);
        run_ld = 0;
        last_load = cyc - 1;
      end
      if (inst[1]) begin
        run_ex++;
        armed = 1'b1;
      end else if (p_exec) begin
        execq.push_back(run_ex);
        run_ex = 0;
        last_ex = cyc - 1;
      end
      if (inst[6] && armed) begin
        latq.push_back(cyc - last_ex);
        armed = 1'b0;
      end
      if (core_reset) cres_n++;
      if (out_valid) begin
        ovq.push_back(int'(out_idx));
        if (last_pr != cyc - 2) bad_ov++;
        last_ov = cyc;
      end
      if (done) begin
        done_n++;
        done_gap = cyc - last_ov;
        if (busy) bad_misc++;
      end
    end
    p_cenx  = cenx;
    p_rd    = inst[6];
    p_pread = pr;
    p_valid = ofifo_valid;
    p_load  = inst[0];
    p_exec  = inst[1];
  end

  int exp_x[$];
  int exp_pw[$];
  int exp_pr[$];
  int acc_spot[9] = '{0, 37, 74, 114, 151, 188, 228, 265, 302};

  initial begin
    #1 reset = 1'b0;
    #1;
    chk("rst_inst", inst, IDLE_INST);
    chk("rst_busy", busy, 0);
    chk("rst_core_reset", core_reset, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_done", done, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("start_clr", core_reset, 1);
    chk("start_busy", busy, 1);
    chk("clr_inst", inst, IDLE_INST);

    for (int c = 0; c < 400 && !inst[1]; c++) begin
      @(posedge clk); #1;
    end
    chk("exec_reached", inst[1], 1);
    #2 reset = 1'b0;
    #1;
    chk("abort_inst", inst, IDLE_INST);
    chk("abort_busy", busy, 0);
    chk("abort_core_reset", core_reset, 0);
    @(posedge clk); #1 reset = 1'b1;
    mon_en = 1'b1;

    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("restart_clr", core_reset, 1);
    @(posedge clk); #1;
    chk("restart_xaddr", inst[17:7], 11'h400);
    chk("restart_cenx", inst[19], 0);

    for (int c = 0; c < 20000 && done_n == 0; c++) begin
      @(posedge clk); #1;
      start = busy && ($urandom_range(0, 199) == 0);
    end
    start = 1'b0;
    chk("done_seen", done_n != 0, 1);
    repeat (4) @(posedge clk);
    #1;
    chk("done_count", done_n, 1);
    chk("done_after_last_ov", done_gap, 1);
    chk("idle_inst", inst, IDLE_INST);
    chk("idle_busy", busy, 0);
    chk("core_reset_pulses", cres_n, KIJ + ONIJ);
    chk("l0_wr_count", l0_n, KIJ * (COL + NIJ));
    chk("l0_wr_lag", bad_l0, 0);
    chk("pmem_wr_lag", bad_pw, 0);
    chk("acc_lag", bad_acc, 0);
    chk("pop_without_valid", bad_pop, 0);
    chk("unused_fields", bad_misc, 0);
    chk("out_valid_timing", bad_ov, 0);

    for (int k = 0; k < KIJ; k++) begin
      for (int j = 0; j < COL; j++) exp_x.push_back('h400 + k * COL + j);
      for (int n = 0; n < NIJ; n++) exp_x.push_back(n);
      for (int n = 0; n < NIJ; n++) exp_pw.push_back(k * NIJ + n);
    end
    for (int o = 0; o < ONIJ; o++)
      for (int k = 0; k < KIJ; k++)
        exp_pr.push_back(k * NIJ
          + (o / OUT_W + k / KER_W) * IN_W + (o % OUT_W + k % KER_W));

    chk("xaddr_count", xq.size(), exp_x.size());
    for (int i = 0; i < exp_x.size(); i++)
      chk("xaddr", (i < xq.size()) ? xq[i] : 11'h7ff, exp_x[i]);
    chk("spill_count", pwq.size(), exp_pw.size());
    for (int i = 0; i < exp_pw.size(); i++)
      chk("spill_addr", (i < pwq.size()) ? pwq[i] : 11'h7ff, exp_pw[i]);
    chk("accrd_count", prq.size(), exp_pr.size());
    for (int i = 0; i < exp_pr.size(); i++)
      chk("acc_addr", (i < prq.size()) ? prq[i] : 11'h7ff, exp_pr[i]);
    for (int k = 0; k < KIJ; k++)
      chk("acc_o0", (k < prq.size()) ? prq[k] : 11'h7ff, acc_spot[k]);
    chk("acc_o5_k4", (prq.size() > 49) ? prq[49] : 11'h7ff, 158);
    chk("acc_o15_k8", (prq.size() > 143) ? prq[143] : 11'h7ff, 323);

    chk("out_valid_count", ovq.size(), ONIJ);
    for (int o = 0; o < ONIJ; o++)
      chk("out_idx", (o < ovq.size()) ? ovq[o] : -1, o);
    chk("load_runs", loadq.size(), KIJ);
    for (int i = 0; i < loadq.size(); i++) chk("load_len", loadq[i], COL);
    chk("exec_runs", execq.size(), KIJ);
    for (int i = 0; i < execq.size(); i++) chk("exec_len", execq[i], NIJ);
    chk("drain_runs", gapq.size(), KIJ);
    for (int i = 0; i < gapq.size(); i++) chk("drain_gap", gapq[i], DRAIN + 1);
    chk("ofwait_runs", latq.size(), KIJ);
    // valid rises HOLD cycles after FLUSH starts; first pop one cycle later
    for (int i = 0; i < latq.size(); i++)
      chk("ofwait_latency", latq[i], HOLD + 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
